spi_target_rx: RTL

- SPI mode-0 target (peripheral) that sits at the far end of the team's SPI display link and receives the byte stream sent by the SPI master.
- Samples asynchronous sck/cs/mosi/dc pins in the system clock domain and deserialises MSB-first bytes.
- Tags each byte with the dc (command/data) level and buffers it in a small FIFO with a valid/ready output.
- Optionally returns a byte on miso. Used as a display-controller model on the FPGA, and as a loopback checker for the master.

---
 rtl/spi_target_rx.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_target_rx.sv
// ============================================================================
// Module   : spi_target_rx
// Brief    : SPI mode-0 target receiver with dc tagging, FWFT FIFO, miso return
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_target_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sck,
    input  logic                          cs,
    input  logic                          mosi,
    input  logic                          dc,
    output logic                          miso,
    output logic [7:0]                    rx_data,
    output logic                          rx_dc,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_load,
    output logic                          tx_pending,
    output logic [7:0]                    byte_cnt,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_status
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    c_DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Synchronisers reset to 0 so a low cs at reset release keeps us disarmed
    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync, r_dc_sync;
    logic                   r_sck_d, r_cs_d;
    logic                   w_sck_s, w_cs_s, w_mosi_s, w_dc_s;
    logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dc};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_dc_s     = r_dc_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic       w_start, w_end, w_bit_rise, w_bit_fall;
    logic [2:0] r_bit_cnt;
    logic       r_frame_byte;
    logic       w_byte_done, w_abort, w_tx_reload, w_tx_shift;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_DISARMED;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_bit_rise  = 1'b0;
        w_bit_fall  = 1'b0;
        case (r_state)
            ST_DISARMED: begin
                if (w_cs_s) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_end       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_bit_rise = w_sck_rise;
                    w_bit_fall = w_sck_fall;
                end
            end
            default: w_state_nxt = ST_DISARMED;
        endcase
    end

    assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
    assign w_abort     = w_end & (r_bit_cnt != 3'd0);
    // Byte boundary inside a frame: next miso byte is loaded on that sck fall
    assign w_tx_reload = w_start | (w_bit_fall & (r_bit_cnt == 3'd0) & r_frame_byte);
    assign w_tx_shift  = w_bit_fall & ~w_tx_reload;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem_data [FIFO_DEPTH];
    logic          r_mem_dc   [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_shift_in;
    logic [7:0]    w_rx_byte;
    logic          w_full, w_pop, w_push, w_ovf_set;

    assign w_rx_byte = {r_shift_in[6:0], w_mosi_s};
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = rx_valid & rx_ready;
    assign w_push    = w_byte_done & (~w_full | w_pop);
    assign w_ovf_set = w_byte_done & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_rx_byte;
            r_mem_dc[r_wr_ptr]   <= w_dc_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bit counter, shifters, tx holding register, status
    // ------------------------------------------------------------------
    logic [7:0] r_tx_shift, r_tx_reg, r_byte_cnt;
    logic       r_tx_pending, r_overflow, r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 3'd0;
            r_frame_byte <= 1'b0;
            r_shift_in   <= 8'd0;
            r_tx_shift   <= 8'd0;
            r_tx_reg     <= 8'd0;
            r_tx_pending <= 1'b0;
            r_byte_cnt   <= 8'd0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt    <= 3'd0;
                r_frame_byte <= 1'b0;
            end
            if (w_bit_rise) begin
                r_shift_in <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_bit_cnt    <= 3'd0;
                    r_byte_cnt   <= r_byte_cnt + 8'd1;
                    r_frame_byte <= 1'b1;
                end
            end
            if (w_end) r_bit_cnt <= 3'd0;

            if (w_tx_reload) begin
                r_tx_shift   <= r_tx_pending ? r_tx_reg : 8'd0;
                r_tx_pending <= 1'b0;
            end else if (w_tx_shift) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
            // Placed after the reload so a coincident load stays pending
            if (tx_load) begin
                r_tx_reg     <= tx_data;
                r_tx_pending <= 1'b1;
            end

            if (w_ovf_set)       r_overflow <= 1'b1;
            else if (clr_status) r_overflow <= 1'b0;
            if (w_abort)         r_frame_err <= 1'b1;
            else if (clr_status) r_frame_err <= 1'b0;
        end
    end

    assign miso       = (r_state == ST_ACTIVE) & r_tx_shift[7];
    assign rx_valid   = (r_count != '0);
    assign rx_data    = rx_valid ? r_mem_data[r_rd_ptr] : 8'd0;
    assign rx_dc      = rx_valid ? r_mem_dc[r_rd_ptr] : 1'b0;
    assign rx_count   = r_count;
    assign tx_pending = r_tx_pending;
    assign byte_cnt   = r_byte_cnt;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire
